// File: rtl/race_pkg.sv
// Shared encodings for the race round sequencer: FSM states, winner codes and
// the target-key LFSR definition.
package race_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StReady = 2'b01,
    StRace  = 2'b10,
    StDone  = 2'b11
  } race_state_e;

  localparam logic [1:0] WinNone   = 2'b00;
  localparam logic [1:0] WinPlayer = 2'b01;
  localparam logic [1:0] WinPc     = 2'b10;
  localparam logic [1:0] WinTie    = 2'b11;

  localparam int unsigned LfsrWidth = 8;
  // x^8 + x^6 + x^5 + x^4 + 1 -> feedback from bits 7, 5, 4, 3
  localparam logic [LfsrWidth-1:0] LfsrTaps = 8'hB8;

  function automatic logic [LfsrWidth-1:0] lfsr_next(input logic [LfsrWidth-1:0] s);
    return {s[LfsrWidth-2:0], ^(s & LfsrTaps)};
  endfunction

endpackage

// File: rtl/race_step_timer.sv
// Free-running period timer: counts 0..period-1 while enabled, pulses expire on
// the last count and wraps. Clear forces the count back to zero.
module race_step_timer #(
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clear,
  input  logic             enable,
  input  logic [Width-1:0] period,
  output logic             expire
);

  localparam logic [Width-1:0] One = Width'(1);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    expire  = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      if (count_q == period - One) begin
        count_d = '0;
        expire  = 1'b1;
      end else begin
        count_d = count_q + One;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/race_round_ctrl.sv
// One race round: start countdown, LFSR target keys, player key checking, paced
// PC opponent and winner decision. All outputs come straight from flops.
module race_round_ctrl
  import race_pkg::*;
#(
  parameter int unsigned TICK_CYCLES    = 50_000_000,
  parameter int unsigned PC_STEP_CYCLES = 12_500_000,
  parameter int unsigned START_COUNT    = 3,
  parameter logic [7:0]  LFSR_SEED      = 8'hA5
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic       key_valid,
  input  logic [1:0] key_code,
  input  logic [1:0] level,
  input  logic       player_ended,
  input  logic       pc_ended,
  output logic       counters_resetn,
  output logic       player_correct,
  output logic       pc_correct,
  output logic       wrong,
  output logic [1:0] target_key,
  output logic [3:0] countdown,
  output logic [1:0] state,
  output logic [1:0] winner
);

  race_state_e          state_q, state_d;
  logic [LfsrWidth-1:0] lfsr_q, lfsr_d;
  logic [1:0]           level_q, level_d;
  logic [1:0]           target_q, target_d;
  logic [1:0]           winner_q, winner_d;
  logic [3:0]           countdown_q, countdown_d;
  logic                 cres_q, cres_d;
  logic                 player_correct_q, player_correct_d;
  logic                 pc_correct_q, pc_correct_d;
  logic                 wrong_q, wrong_d;
  logic                 tick, pc_expire;
  logic [31:0]          pc_period;

  assign pc_period = (32'd4 - 32'(level_q)) * PC_STEP_CYCLES;

  race_step_timer #(.Width(32)) u_tick_timer (
    .clk    (clk),
    .resetn (resetn),
    .clear  (state_q != StReady),
    .enable (state_q == StReady),
    .period (32'(TICK_CYCLES)),
    .expire (tick)
  );

  race_step_timer #(.Width(32)) u_pc_timer (
    .clk    (clk),
    .resetn (resetn),
    .clear  (state_q != StRace),
    .enable (state_q == StRace),
    .period (pc_period),
    .expire (pc_expire)
  );

  always_comb begin
    state_d          = state_q;
    lfsr_d           = lfsr_next(lfsr_q);
    level_d          = level_q;
    target_d         = target_q;
    winner_d         = winner_q;
    countdown_d      = countdown_q;
    cres_d           = cres_q;
    player_correct_d = 1'b0;
    pc_correct_d     = 1'b0;
    wrong_d          = 1'b0;
    case (state_q)
      StIdle: begin
        cres_d   = 1'b0;
        winner_d = WinNone;
        if (start) begin
          state_d     = StReady;
          countdown_d = 4'(START_COUNT);
          level_d     = level;
          cres_d      = 1'b1;
        end
      end
      StReady: begin
        if (tick) begin
          if (countdown_q == 4'd1) begin
            state_d     = StRace;
            countdown_d = 4'd0;
            target_d    = lfsr_q[1:0];
          end else begin
            countdown_d = countdown_q - 4'd1;
          end
        end
      end
      StRace: begin
        // Once either counter reports ended, no further pulses may reach them.
        if (player_ended || pc_ended) begin
          state_d = StDone;
          if (player_ended && pc_ended) winner_d = WinTie;
          else if (player_ended)        winner_d = WinPlayer;
          else                          winner_d = WinPc;
        end else begin
          if (key_valid) begin
            if (key_code == target_q) begin
              player_correct_d = 1'b1;
              target_d         = lfsr_q[1:0];
            end else begin
              wrong_d = 1'b1;
            end
          end
          pc_correct_d = pc_expire;
        end
      end
      StDone: begin
        if (start) begin
          state_d  = StIdle;
          winner_d = WinNone;
          cres_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q          <= StIdle;
      lfsr_q           <= LFSR_SEED;
      level_q          <= 2'd0;
      target_q         <= 2'd0;
      winner_q         <= WinNone;
      countdown_q      <= 4'd0;
      cres_q           <= 1'b0;
      player_correct_q <= 1'b0;
      pc_correct_q     <= 1'b0;
      wrong_q          <= 1'b0;
    end else begin
      state_q          <= state_d;
      lfsr_q           <= lfsr_d;
      level_q          <= level_d;
      target_q         <= target_d;
      winner_q         <= winner_d;
      countdown_q      <= countdown_d;
      cres_q           <= cres_d;
      player_correct_q <= player_correct_d;
      pc_correct_q     <= pc_correct_d;
      wrong_q          <= wrong_d;
    end
  end

  assign state           = state_q;
  assign target_key      = target_q;
  assign winner          = winner_q;
  assign countdown       = countdown_q;
  assign counters_resetn = cres_q;
  assign player_correct  = player_correct_q;
  assign pc_correct      = pc_correct_q;
  assign wrong           = wrong_q;

endmodule

// File: tb/tb_race_round_ctrl.sv
// Directed bench for race_round_ctrl with modelled score counters, an LFSR model
// and a scoreboard of expected key outcomes.
module tb_race_round_ctrl;

  localparam int unsigned TickCycles = 4;
  localparam int unsigned PcStep     = 2;
  localparam int unsigned StartCount = 3;
  localparam logic [7:0]  Seed       = 8'hA5;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic       key_valid = 1'b0;
  logic [1:0] key_code = 2'd0;
  logic [1:0] level = 2'd0;
  logic       player_ended, pc_ended;
  logic       counters_resetn, player_correct, pc_correct, wrong;
  logic [1:0] target_key, state, winner;
  logic [3:0] countdown;

  race_round_ctrl #(
    .TICK_CYCLES    (TickCycles),
    .PC_STEP_CYCLES (PcStep),
    .START_COUNT    (StartCount),
    .LFSR_SEED      (Seed)
  ) dut (
    .clk             (clk),
    .resetn          (resetn),
    .start           (start),
    .key_valid       (key_valid),
    .key_code        (key_code),
    .level           (level),
    .player_ended    (player_ended),
    .pc_ended        (pc_ended),
    .counters_resetn (counters_resetn),
    .player_correct  (player_correct),
    .pc_correct      (pc_correct),
    .wrong           (wrong),
    .target_key      (target_key),
    .countdown       (countdown),
    .state           (state),
    .winner          (winner)
  );

  always #5 clk = ~clk;

  // Score counter models: start at 32, ended on the pulse that arrives at 0.
  int   pl_cnt = 32, pc_cnt = 32;
  logic pl_end_m = 1'b0, pc_end_m = 1'b0;
  logic tie_mode = 1'b0, tie_val = 1'b0;

  always @(posedge clk) begin
    if (counters_resetn === 1'b0) begin
      pl_cnt <= 32; pc_cnt <= 32; pl_end_m <= 1'b0; pc_end_m <= 1'b0;
    end else begin
      if (player_correct === 1'b1) begin
        if (pl_cnt == 0) pl_end_m <= 1'b1; else pl_cnt <= pl_cnt - 1;
      end
      if (pc_correct === 1'b1) begin
        if (pc_cnt == 0) pc_end_m <= 1'b1; else pc_cnt <= pc_cnt - 1;
      end
    end
  end

  assign player_ended = tie_mode ? tie_val : pl_end_m;
  assign pc_ended     = tie_mode ? tie_val : pc_end_m;

  logic [7:0] lfsr_m = Seed;
  always @(posedge clk) begin
    lfsr_m <= !resetn ? Seed : {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
  end

  typedef struct {
    int         cyc;
    logic       corr;
    logic       wr;
    logic [1:0] tgt;
  } exp_t;
  exp_t exp_q[$];

  int         n_tests = 0, n_fail = 0;
  int         cyc = 0, last_pc = 0, pc_period = 8, n_pc = 0, n_pl = 0;
  int         pl0, pc0;
  logic       pc_allowed = 1'b0;
  logic [7:0] lfsr_prev = Seed;
  logic [1:0] exp_target = 2'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Advance to the next negedge and check pulses against the scoreboard.
  task automatic cycle();
    logic allow;
    exp_t e;
    allow     = pc_allowed && !player_ended && !pc_ended;
    lfsr_prev = lfsr_m;
    @(negedge clk);
    cyc++;
    if (player_correct === 1'b1) n_pl++;
    if (pc_correct === 1'b1) n_pc++;
    if (!allow) begin
      chk("pc_quiet", 32'(pc_correct), 32'd0);
    end else if (pc_correct === 1'b1) begin
      chk("pc_interval", 32'(cyc - last_pc), 32'(pc_period));
      last_pc = cyc;
    end
    if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      chk("player_correct", 32'(player_correct), 32'(e.corr));
      chk("wrong", 32'(wrong), 32'(e.wr));
      chk("target_key", 32'(target_key), 32'(e.tgt));
    end else begin
      chk("no_key_pulse", 32'({player_correct, wrong}), 32'd0);
    end
  endtask

  // kind: 0 matching key, 1 mismatched key, 2 key outside RACE (ignored)
  task automatic press(input int kind);
    key_valid = 1'b1;
    if (kind == 0) begin
      key_code = exp_target;
      exp_q.push_back('{cyc + 1, 1'b1, 1'b0, lfsr_m[1:0]});
      exp_target = lfsr_m[1:0];
    end else if (kind == 1) begin
      key_code = exp_target ^ 2'b01;
      exp_q.push_back('{cyc + 1, 1'b0, 1'b1, exp_target});
    end else begin
      key_code = exp_target;
      exp_q.push_back('{cyc + 1, 1'b0, 1'b0, exp_target});
    end
    cycle();
    key_valid = 1'b0;
  endtask

  task automatic do_start(input logic [1:0] lvl);
    start = 1'b1;
    level = lvl;
    cycle();
    start = 1'b0;
    level = ~lvl;
    for (int t = 1; t <= 12; t++) begin
      if (t > 1) cycle();
      chk("ready_state", 32'(state), 32'd1);
      chk("countdown", 32'(countdown), 32'(3 - (t - 1) / 4));
      chk("cres_ready", 32'(counters_resetn), 32'd1);
    end
    cycle();
    chk("race_state", 32'(state), 32'd2);
    chk("race_countdown", 32'(countdown), 32'd0);
    chk("race_target", 32'(target_key), 32'(lfsr_prev[1:0]));
    exp_target = lfsr_prev[1:0];
    pc_period  = (4 - int'(lvl)) * int'(PcStep);
    last_pc    = cyc;
    pc_allowed = 1'b1;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_state"}, 32'(state), 32'd0);
    chk({tag, "_cres"}, 32'(counters_resetn), 32'd0);
    chk({tag, "_countdown"}, 32'(countdown), 32'd0);
    chk({tag, "_target"}, 32'(target_key), 32'd0);
    chk({tag, "_winner"}, 32'(winner), 32'd0);
    chk({tag, "_pulses"}, 32'({player_correct, pc_correct, wrong}), 32'd0);
  endtask

  initial begin
    repeat (3) cycle();
    check_reset_values("reset");
    resetn = 1'b1;
    cycle();
    chk("idle_state", 32'(state), 32'd0);
    chk("idle_cres", 32'(counters_resetn), 32'd0);

    // Level 0: one wrong key, then 33 matching keys every 2 cycles.
    do_start(2'd0);
    press(1);
    cycle();
    pl0 = n_pl;
    for (int i = 0; i < 33; i++) begin
      press(0);
      cycle();
    end
    chk("player_pulses", 32'(n_pl - pl0), 32'd33);
    chk("exit_pending_state", 32'(state), 32'd2);
    cycle();
    chk("player_done_state", 32'(state), 32'd3);
    chk("player_winner", 32'(winner), 32'd1);
    pc_allowed = 1'b0;
    for (int i = 0; i < 4; i++) press(2);
    cycle();
    chk("done_hold_winner", 32'(winner), 32'd1);
    chk("done_hold_cres", 32'(counters_resetn), 32'd1);
    start = 1'b1;
    cycle();
    start = 1'b0;
    chk("back_idle_state", 32'(state), 32'd0);
    chk("back_idle_winner", 32'(winner), 32'd0);
    cycle();

    // Level 3, no keys: PC every 2 cycles, level input changed after latching.
    do_start(2'd3);
    pc0 = n_pc;
    for (int i = 0; i < 200 && state !== 2'b11; i++) cycle();
    chk("pc_done_state", 32'(state), 32'd3);
    chk("pc_winner", 32'(winner), 32'd2);
    chk("pc_pulses", 32'(n_pc - pc0), 32'd33);
    chk("pc_done_latency", 32'(cyc - last_pc), 32'd2);
    pc_allowed = 1'b0;
    start = 1'b1;
    cycle();
    start = 1'b0;
    chk("pc_idle_winner", 32'(winner), 32'd0);
    cycle();

    // Both counters end in the same cycle.
    do_start(2'd1);
    repeat (3) cycle();
    tie_mode = 1'b1;
    tie_val  = 1'b1;
    cycle();
    chk("tie_state", 32'(state), 32'd3);
    chk("tie_winner", 32'(winner), 32'd3);
    pc_allowed = 1'b0;
    start = 1'b1;
    cycle();
    start = 1'b0;
    chk("tie_idle_state", 32'(state), 32'd0);
    chk("tie_idle_winner", 32'(winner), 32'd0);
    chk("tie_idle_cres", 32'(counters_resetn), 32'd0);
    tie_mode = 1'b0;
    tie_val  = 1'b0;
    cycle();

    // Reset in the middle of a race.
    do_start(2'd2);
    press(0);
    cycle();
    press(0);
    cycle();
    pc_allowed = 1'b0;
    resetn = 1'b0;
    cycle();
    check_reset_values("midrace_reset");
    resetn = 1'b1;
    exp_target = 2'd0;
    for (int i = 0; i < 3; i++) press(2);
    cycle();
    chk("post_reset_idle", 32'(state), 32'd0);
    chk("post_reset_cres", 32'(counters_resetn), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
